ctrl_pipe_unit: RTL and testbench

Parametrised pipelined control unit for the 5-stage MIPS core. Decodes the ID-stage opcode into a control bundle, then carries that bundle through the ID/EX, EX/MEM and MEM/WB stage registers. Each stage's controls therefore arrive aligned with its datapath. Adds load-use hazard detection with stall, branch flush, a global freeze, BNE decode, and optional illegal-opcode trapping.

---
 rtl/ctrl_pipe_unit.sv | 218 +++++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// rtl/ctrl_pipe_unit.sv - pipelined MIPS control: decode, ID/EX/MEM/WB control registers, load-use stall, flush, freeze
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (sticky illegal-opcode flag)
module ctrl_pipe_unit #(
  parameter int RA_W    = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_reg,
  input  logic [5:0]         opcode,
  input  logic [RA_W-1:0]    id_rs,
  input  logic [RA_W-1:0]    id_rt,
  input  logic [RA_W-1:0]    id_rd,
  input  logic               flush,
  output logic               stall,
  output logic               id_ExtendSel,
  output logic               ex_RegDst,
  output logic               ex_ALUSrc,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic [RA_W-1:0]    ex_dst,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               mem_Branch,
  output logic               mem_BranchNe,
  output logic               mem_Jump,
  output logic [RA_W-1:0]    mem_dst,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [RA_W-1:0]    wb_dst,
  output logic               illegal_op
);

  localparam logic [5:0] OP_R     = 6'd0;
  localparam logic [5:0] OP_MADDU = 6'd28;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_J     = 6'd2;

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic               branchne;
    logic               jump;
    logic [RA_W-1:0]    dst;
  } ex_ctl_t;

  typedef struct packed {
    logic            memtoreg;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            branch;
    logic            branchne;
    logic            jump;
    logic [RA_W-1:0] dst;
  } mem_ctl_t;

  typedef struct packed {
    logic            regwrite;
    logic            memtoreg;
    logic [RA_W-1:0] dst;
  } wb_ctl_t;

  ex_ctl_t  idex_d, idex_q;
  mem_ctl_t exmem_d, exmem_q;
  wb_ctl_t  memwb_d, memwb_q;
  logic     ext_sel;
  logic     rs_use;
  logic     rt_use;

  // Opcode decode into the ID/EX bundle; unknown opcodes fall through to a NOP
  always_comb begin
    idex_d   = '0;
    ext_sel  = 1'b0;
    rs_use   = 1'b1;
    rt_use   = 1'b0;
    case (opcode)
      OP_R, OP_MADDU: begin
        idex_d.regdst   = 1'b1;
        idex_d.regwrite = 1'b1;
        idex_d.aluop    = ALUOP_W'(2'd2);
        rt_use          = 1'b1;
      end
      OP_ADDIU: begin
        idex_d.alusrc   = 1'b1;
        idex_d.regwrite = 1'b1;
      end
      OP_LW: begin
        idex_d.alusrc   = 1'b1;
        idex_d.memtoreg = 1'b1;
        idex_d.regwrite = 1'b1;
        idex_d.memread  = 1'b1;
        ext_sel         = 1'b1;
      end
      OP_SW: begin
        idex_d.alusrc   = 1'b1;
        idex_d.memwrite = 1'b1;
        ext_sel         = 1'b1;
        rt_use          = 1'b1;
      end
      OP_BEQ: begin
        idex_d.branch   = 1'b1;
        idex_d.aluop    = ALUOP_W'(2'd1);
        ext_sel         = 1'b1;
        rt_use          = 1'b1;
      end
      OP_BNE: begin
        idex_d.branch   = 1'b1;
        idex_d.branchne = 1'b1;
        idex_d.aluop    = ALUOP_W'(2'd1);
        ext_sel         = 1'b1;
        rt_use          = 1'b1;
      end
      OP_J: begin
        idex_d.branch   = 1'b1;
        idex_d.jump     = 1'b1;
        idex_d.aluop    = ALUOP_W'(2'd1);
        ext_sel         = 1'b1;
        rs_use          = 1'b0;
      end
      default: ;
    endcase
    // A non-writing instruction carries dst 0 so it can never trigger a hazard
    if (idex_d.regwrite)
      idex_d.dst = idex_d.regdst ? id_rd : id_rt;
  end

  assign id_ExtendSel = ext_sel;

  // Load-use hazard: a load in EX whose target is read by the instruction in ID
  always_comb begin
    stall = 1'b0;
    if (!rst && en_reg && idex_q.memread && (idex_q.dst != '0))
      stall = ((idex_q.dst == id_rs) && rs_use) || ((idex_q.dst == id_rt) && rt_use);
  end

  // Next-state for the later stages is a plain forward of the previous stage
  always_comb begin
    exmem_d          = '0;
    exmem_d.memtoreg = idex_q.memtoreg;
    exmem_d.regwrite = idex_q.regwrite;
    exmem_d.memread  = idex_q.memread;
    exmem_d.memwrite = idex_q.memwrite;
    exmem_d.branch   = idex_q.branch;
    exmem_d.branchne = idex_q.branchne;
    exmem_d.jump     = idex_q.jump;
    exmem_d.dst      = idex_q.dst;
    memwb_d          = '0;
    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.dst      = exmem_q.dst;
  end

  // Stage registers: reset, freeze, flush (beats stall), stall bubble, advance
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else if (en_reg) begin
      memwb_q <= memwb_d;
      if (flush) begin
        idex_q  <= '0;
        exmem_q <= '0;
      end else begin
        exmem_q <= exmem_d;
        idex_q  <= stall ? '0 : idex_d;
      end
    end
  end

  assign ex_RegDst    = idex_q.regdst;
  assign ex_ALUSrc    = idex_q.alusrc;
  assign ex_ALUOp     = idex_q.aluop;
  assign ex_dst       = idex_q.dst;
  assign mem_MemRead  = exmem_q.memread;
  assign mem_MemWrite = exmem_q.memwrite;
  assign mem_Branch   = exmem_q.branch;
  assign mem_BranchNe = exmem_q.branchne;
  assign mem_Jump     = exmem_q.jump;
  assign mem_dst      = exmem_q.dst;
  assign wb_RegWrite  = memwb_q.regwrite;
  assign wb_MemtoReg  = memwb_q.memtoreg;
  assign wb_dst       = memwb_q.dst;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic known_op;

  // Opcodes the decoder recognises; anything else is trapped
  always_comb begin
    known_op = opcode inside {OP_R, OP_MADDU, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  end

  // Sticky trap flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (en_reg && !stall && !known_op)
      illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Edge-triggered stage enable only; unused inputs of upper bits are none
endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb/tb_ctrl_pipe_unit.sv - table-driven scoreboard bench for ctrl_pipe_unit
module tb_ctrl_pipe_unit;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam int TRAP = 1;
`else
  localparam int TRAP = 0;
`endif

  localparam int R = 0, AD = 9, LW = 35, SW = 43, BEQ = 4, BNE = 5, J = 2, MA = 28, BAD = 63;

  logic       clk = 1'b0;
  logic       rst, en_reg, flush;
  logic [5:0] opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       stall, id_ExtendSel;
  logic       ex_RegDst, ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic [4:0] ex_dst, mem_dst, wb_dst;
  logic       mem_MemRead, mem_MemWrite, mem_Branch, mem_BranchNe, mem_Jump;
  logic       wb_RegWrite, wb_MemtoReg, illegal_op;

  ctrl_pipe_unit #(.RA_W(5), .ALUOP_W(2)) dut (
    .clk(clk), .rst(rst), .en_reg(en_reg), .opcode(opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .stall(stall), .id_ExtendSel(id_ExtendSel),
    .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_dst(ex_dst),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Branch(mem_Branch),
    .mem_BranchNe(mem_BranchNe), .mem_Jump(mem_Jump), .mem_dst(mem_dst),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, fl;
    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [1:0] comb;   // {stall, ExtendSel} before the edge
    logic [8:0] ex;     // {RegDst, ALUSrc, ALUOp, dst}
    logic [9:0] mem;    // {MemRead, MemWrite, Branch, BranchNe, Jump, dst}
    logic [6:0] wb;     // {RegWrite, MemtoReg, dst}
    logic       ill;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input int rs_, en, fl, op, rs, rt, rd, st, ext,
                              input int rdst, asrc, aop, exd,
                              input int mr, mw, br, bne, jp, md,
                              input int rw, mtr, wd, ill);
    vec_t v;
    v.rst  = 1'(rs_);  v.en = 1'(en); v.fl = 1'(fl);
    v.op   = 6'(op);   v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
    v.comb = {1'(st), 1'(ext)};
    v.ex   = {1'(rdst), 1'(asrc), 2'(aop), 5'(exd)};
    v.mem  = {1'(mr), 1'(mw), 1'(br), 1'(bne), 1'(jp), 5'(md)};
    v.wb   = {1'(rw), 1'(mtr), 5'(wd)};
    v.ill  = 1'(ill);
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h expected %h", name, row, got, exp);
    end
  endtask

  initial begin
    vec_t e;
    rst = 1'b1; en_reg = 1'b1; flush = 1'b0; opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;

    //              rst en fl op  rs rt rd  st ex   RD AS AO ED   MR MW BR BN J  MD   RW MR WD  ILL
    vecs.push_back(mk(1, 1, 0, R,   0, 0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, AD,  1, 3, 7,  0, 0,  0, 1, 0, 3,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   0, 0, 0,  0, 0,  1, 0, 2, 0,   0, 0, 0, 0, 0, 3,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   0, 0, 0,  0, 0,  1, 0, 2, 0,   0, 0, 0, 0, 0, 0,   1, 0, 3,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 4, 0,  0, 1,  0, 1, 0, 4,   0, 0, 0, 0, 0, 0,   1, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   4, 2, 6,  1, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 4,   1, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   4, 2, 6,  0, 0,  1, 0, 2, 6,   0, 0, 0, 0, 0, 0,   1, 1, 4,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 0, 0,  0, 1,  0, 1, 0, 0,   0, 0, 0, 0, 0, 6,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   0, 0, 9,  0, 0,  1, 0, 2, 9,   1, 0, 0, 0, 0, 0,   1, 0, 6,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 5, 0,  0, 1,  0, 1, 0, 5,   0, 0, 0, 0, 0, 9,   1, 1, 0,  0));
    vecs.push_back(mk(0, 1, 0, AD,  1, 5, 0,  0, 0,  0, 1, 0, 5,   1, 0, 0, 0, 0, 5,   1, 0, 9,  0));
    vecs.push_back(mk(0, 1, 0, BNE, 2, 3, 0,  0, 1,  0, 0, 1, 0,   0, 0, 0, 0, 0, 5,   1, 1, 5,  0));
    vecs.push_back(mk(0, 1, 0, SW,  1, 7, 0,  0, 1,  0, 1, 0, 0,   0, 0, 1, 1, 0, 0,   1, 0, 5,  0));
    vecs.push_back(mk(0, 1, 1, AD,  1, 8, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, J,   0, 0, 0,  0, 1,  0, 0, 1, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   1, 2, 10, 0, 0,  1, 0, 2, 10,  0, 0, 1, 0, 1, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 1, AD,  1, 11, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   0, 0, 12, 0, 0,  1, 0, 2, 12,  0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   0, 0, 13, 0, 0,  1, 0, 2, 13,  0, 0, 0, 0, 0, 12,  0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 1, R,   0, 0, 14, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   1, 0, 12, 0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 4, 0,  0, 1,  0, 1, 0, 4,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 1, R,   4, 0, 15, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   4, 0, 15, 0, 0,  1, 0, 2, 15,  0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 6, 0,  0, 1,  0, 1, 0, 6,   0, 0, 0, 0, 0, 15,  0, 0, 0,  0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, R, 6, 0, 16, 0, 0,  0, 1, 0, 6,   0, 0, 0, 0, 0, 15,  0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, R,   6, 0, 16, 1, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 6,   1, 0, 15, 0));
    vecs.push_back(mk(0, 1, 0, R,   6, 0, 16, 0, 0,  1, 0, 2, 16,  0, 0, 0, 0, 0, 0,   1, 1, 6,  0));
    vecs.push_back(mk(1, 1, 0, AD,  1, 3, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, BAD, 0, 0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  TRAP));
    vecs.push_back(mk(0, 1, 0, AD,  1, 3, 0,  0, 0,  0, 1, 0, 3,   0, 0, 0, 0, 0, 0,   0, 0, 0,  TRAP));
    vecs.push_back(mk(0, 1, 0, AD,  1, 3, 0,  0, 0,  0, 1, 0, 3,   0, 0, 0, 0, 0, 3,   0, 0, 0,  TRAP));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 1, 0, AD, 1, 3, 0, 0, 0,  0, 1, 0, 3,   0, 0, 0, 0, 0, 3,   1, 0, 3,  TRAP));
    vecs.push_back(mk(1, 1, 0, R,   0, 0, 0,  0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 7, 0,  0, 1,  0, 1, 0, 7,   0, 0, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, SW,  1, 7, 0,  1, 1,  0, 0, 0, 0,   1, 0, 0, 0, 0, 7,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, SW,  1, 7, 0,  0, 1,  0, 1, 0, 0,   0, 0, 0, 0, 0, 0,   1, 1, 7,  0));
    vecs.push_back(mk(0, 1, 0, LW,  1, 8, 0,  0, 1,  0, 1, 0, 8,   0, 1, 0, 0, 0, 0,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, J,   8, 8, 0,  0, 1,  0, 0, 1, 0,   1, 0, 0, 0, 0, 8,   0, 0, 0,  0));
    vecs.push_back(mk(0, 1, 0, MA,  1, 2, 17, 0, 0,  1, 0, 2, 17,  0, 0, 1, 0, 1, 0,   1, 1, 8,  0));
    vecs.push_back(mk(0, 1, 0, BEQ, 1, 2, 0,  0, 1,  0, 0, 1, 0,   0, 0, 0, 0, 0, 17,  0, 0, 0,  0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; en_reg = vecs[i].en; flush = vecs[i].fl;
      opcode = vecs[i].op; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
      sb.push_back(vecs[i]);
      #1;
      chk("comb_stall_ext", i, 32'({stall, id_ExtendSel}), 32'(sb[0].comb));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("ex_stage", i, 32'({ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_dst}), 32'(e.ex));
      chk("mem_stage", i, 32'({mem_MemRead, mem_MemWrite, mem_Branch, mem_BranchNe, mem_Jump, mem_dst}), 32'(e.mem));
      chk("wb_stage", i, 32'({wb_RegWrite, wb_MemtoReg, wb_dst}), 32'(e.wb));
      chk("illegal_op", i, 32'(illegal_op), 32'(e.ill));
    end

    chk("scoreboard_empty", vecs.size(), 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
